// File: rtl/exp2_rsa_dec.sv
// 256-bit RSA decryption engine (m = c^d mod n) with a byte-wide register-file host port.
// Left-to-right square-and-multiply over a bit-serial interleaved modular multiplier.
module exp2_rsa_dec #(
  parameter int WIDTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  output logic       ready,
  input  logic       we,
  input  logic       oe,
  input  logic       start,
  input  logic [1:0] reg_sel,
  input  logic [4:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       clk_o,
  output logic       reset_o,
  output logic       ready_o,
  output logic       we_o,
  output logic       oe_o,
  output logic       start_o,
  output logic [1:0] reg_sel_o,
  output logic [4:0] addr_o,
  output logic [7:0] data_i_o
);

  localparam int RW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {PH_EXP, PH_MUL} phase_t;

  state_t state;
  phase_t phase;

  logic [WIDTH-1:0] n_reg, d_reg, c_reg, m_reg;
  logic [WIDTH-1:0] wn, wd, wc, acc, ma, mb;
  logic [8:0]       ecnt, mcnt, c_len;
  logic [RW-1:0]    r;
  logic             is_sq;
  logic [8:0]       d_lz, c_lz, acc_lz;

  // Leading zeros are skipped: they leave acc = 1 (exponent) or r = 0 (multiplier) unchanged.
  function automatic logic [8:0] lzc(input logic [WIDTH-1:0] v);
    logic [8:0] z;
    z = 9'd256;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) z = 9'(WIDTH - 1 - i);
    return z;
  endfunction

  function automatic logic [RW-1:0] mod_step(input logic [RW-1:0]    r_in,
                                             input logic [WIDTH-1:0] a,
                                             input logic             b_bit,
                                             input logic [WIDTH-1:0] n);
    logic [RW-1:0] t, nn;
    nn = {2'b00, n};
    t  = {r_in[RW-2:0], 1'b0};
    if (t >= nn) t = t - nn;
    if (b_bit) t = t + {2'b00, a};
    if (t >= nn) t = t - nn;
    return t;
  endfunction

  assign d_lz   = lzc(d_reg);
  assign c_lz   = lzc(c_reg);
  assign acc_lz = lzc(acc);

  assign clk_o     = clk;
  assign reset_o   = reset;
  assign ready_o   = ready;
  assign we_o      = we;
  assign oe_o      = oe;
  assign start_o   = start;
  assign reg_sel_o = reg_sel;
  assign addr_o    = addr;
  assign data_i_o  = data_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg  <= '0;
      d_reg  <= '0;
      c_reg  <= '0;
      data_o <= '0;
    end else begin
      if (we && state != BUSY) begin
        case (reg_sel)
          2'd3:    n_reg[{addr, 3'b000} +: 8] <= data_i;
          2'd2:    d_reg[{addr, 3'b000} +: 8] <= data_i;
          2'd1:    c_reg[{addr, 3'b000} +: 8] <= data_i;
          default: ;
        endcase
      end
      if (oe) data_o <= m_reg[{addr, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= PH_EXP;
      ready <= 1'b0;
      m_reg <= '0;
      wn    <= '0;
      wd    <= '0;
      wc    <= '0;
      acc   <= '0;
      ma    <= '0;
      mb    <= '0;
      ecnt  <= '0;
      mcnt  <= '0;
      c_len <= '0;
      r     <= '0;
      is_sq <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= BUSY;
            phase <= PH_EXP;
            ready <= 1'b0;
            wn    <= n_reg;
            wd    <= d_reg << d_lz;
            ecnt  <= 9'd256 - d_lz;
            wc    <= c_reg << c_lz;
            c_len <= 9'd256 - c_lz;
            acc   <= WIDTH'(1);
          end
        end
        BUSY: begin
          case (phase)
            PH_EXP: begin
              if (ecnt == 9'd0) begin
                m_reg <= acc;
                ready <= 1'b1;
                state <= DONE;
              end else begin
                // load cycle of the squaring acc*acc
                ma    <= acc;
                mb    <= acc << acc_lz;
                mcnt  <= 9'd256 - acc_lz;
                r     <= '0;
                is_sq <= 1'b1;
                phase <= PH_MUL;
              end
            end
            PH_MUL: begin
              if (mcnt != 9'd0) begin
                r    <= mod_step(r, ma, mb[WIDTH-1], wn);
                mb   <= mb << 1;
                mcnt <= mcnt - 9'd1;
              end else if (is_sq && wd[WIDTH-1]) begin
                // exponent bit is 1: chain straight into acc*c
                acc   <= r[WIDTH-1:0];
                ma    <= r[WIDTH-1:0];
                mb    <= wc;
                mcnt  <= c_len;
                r     <= '0;
                is_sq <= 1'b0;
              end else begin
                acc   <= r[WIDTH-1:0];
                wd    <= wd << 1;
                ecnt  <= ecnt - 9'd1;
                phase <= PH_EXP;
              end
            end
            default: phase <= PH_EXP;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp2_rsa_dec.sv
// Directed bench for exp2_rsa_dec: small hand-worked vectors, 256-bit moduli with closed-form
// results, a wide-arithmetic reference for a random exponent, busy-time disturbance and reset abort.
`timescale 1ns/1ps
module tb_exp2_rsa_dec;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ready;
  logic       we = 1'b0;
  logic       oe = 1'b0;
  logic       start = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [4:0] addr = 5'd0;
  logic [7:0] data_i = 8'd0;
  logic [7:0] data_o;
  logic       clk_o, reset_o, ready_o, we_o, oe_o, start_o;
  logic [1:0] reg_sel_o;
  logic [4:0] addr_o;
  logic [7:0] data_i_o;

  int n_chk = 0;
  int n_pass = 0;

  localparam int LAT_MAX = 131600;

  exp2_rsa_dec dut (
    .clk(clk), .reset(reset), .ready(ready), .we(we), .oe(oe), .start(start),
    .reg_sel(reg_sel), .addr(addr), .data_i(data_i), .data_o(data_o),
    .clk_o(clk_o), .reset_o(reset_o), .ready_o(ready_o), .we_o(we_o), .oe_o(oe_o),
    .start_o(start_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_i_o(data_i_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] modexp(input logic [255:0] c, input logic [255:0] d,
                                          input logic [255:0] n);
    logic [511:0] base, res, nn;
    nn   = {256'd0, n};
    res  = 512'd1;
    base = {256'd0, c} % nn;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) res = (res * base) % nn;
      base = (base * base) % nn;
    end
    return res[255:0];
  endfunction

  task automatic wr(input logic [1:0] sel, input int a, input logic [7:0] v);
    @(negedge clk);
    we = 1'b1; reg_sel = sel; addr = 5'(a); data_i = v;
  endtask

  task automatic wr_word(input logic [1:0] sel, input logic [255:0] v);
    for (int i = 0; i < 32; i++) wr(sel, i, v[i*8 +: 8]);
    @(negedge clk);
    we = 1'b0; reg_sel = 2'd0;
  endtask

  task automatic start_pulse(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_ready_fall"}, 256'(ready), 256'd0);
  endtask

  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!ready && cnt < LAT_MAX) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_ready_rise"}, 256'(ready), 256'd1);
  endtask

  task automatic run(input string tag);
    start_pulse(tag);
    wait_ready(tag);
  endtask

  task automatic read_m(output logic [255:0] v);
    v = '0;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0) v[(i-1)*8 +: 8] = data_o;
      if (i < 32) begin oe = 1'b1; addr = 5'(i); end
      else oe = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] m, exp, n_big, k, c_rnd, d_rnd;

    #12;
    check("rst_ready", 256'(ready), 256'd0);
    check("rst_data_o", 256'(data_o), 256'd0);
    @(negedge clk); reset = 1'b1;

    @(negedge clk); oe = 1'b0; reg_sel = 2'd0; addr = 5'd19; data_i = 8'hC3; start = 1'b0;
    #1;
    check("mirrors", 256'({reg_sel_o, addr_o, data_i_o, we_o, oe_o, start_o, reset_o, ready_o}),
          256'({2'd0, 5'd19, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));

    // 31^7 mod 33 = (-2)^7 mod 33 = 4
    wr_word(2'd3, 256'd33); wr_word(2'd2, 256'd7); wr_word(2'd1, 256'd31);
    run("t1"); read_m(m); check("t1_m", m, 256'd4);

    // 2^7 mod 33 = 128 - 99 = 29
    wr_word(2'd1, 256'd2);
    run("t2"); read_m(m); check("t2_m", m, 256'h1D);

    wr_word(2'd2, 256'd0);
    run("d0"); read_m(m); check("d0_m", m, 256'd1);

    wr_word(2'd3, 256'd251); wr_word(2'd2, 256'd1); wr_word(2'd1, 256'h55);
    run("d1"); read_m(m); check("d1_m", m, 256'h55);

    wr_word(2'd2, 256'd7); wr_word(2'd1, 256'd0);
    run("c0"); read_m(m); check("c0_m", m, 256'd0);

    // n = 2^255 + k: 2^200 < n, and 2^257 mod n = 2^255 - 3k
    k = 256'h1234_5678;
    n_big = (256'd1 << 255) | k;
    wr_word(2'd3, n_big); wr_word(2'd2, 256'd200); wr_word(2'd1, 256'd2);
    run("p200"); read_m(m);
    exp = 256'd1 << 200;
    check("p200_m", m, exp);

    wr_word(2'd2, 256'd257);
    run("p257"); read_m(m);
    exp = {8'h7F, {27{8'hFF}}, 32'hC962_FC98};
    check("p257_m", m, exp);
    repeat (3) @(negedge clk);
    check("oe_hold", 256'(data_o), 256'h7F);

    c_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    c_rnd[255] = 1'b0;
    d_rnd = 256'($urandom_range(32'hFFFFF, 32'h80000));
    exp = modexp(c_rnd, d_rnd, n_big);
    wr_word(2'd2, d_rnd); wr_word(2'd1, c_rnd);
    start_pulse("mdl");
    repeat (100) @(negedge clk);
    check("mdl_busy", 256'(ready), 256'd0);
    for (int i = 0; i < 4; i++) wr(2'd1, i, 8'hA5);
    @(negedge clk); we = 1'b0; reg_sel = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mdl_busy_start", 256'(ready), 256'd0);
    wait_ready("mdl");
    read_m(m); check("mdl_m", m, exp);

    run("rerun"); read_m(m); check("rerun_m", m, exp);

    start_pulse("abort");
    repeat (300) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", 256'(ready), 256'd0);
    check("abort_data_o", 256'(data_o), 256'd0);
    @(negedge clk); reset = 1'b1;
    read_m(m); check("abort_m", m, 256'd0);

    wr_word(2'd3, 256'd33); wr_word(2'd2, 256'd7); wr_word(2'd1, 256'd31);
    run("fresh"); read_m(m); check("fresh_m", m, 256'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
